// File: rtl/nco_mc_pkg.sv
// Shared types and constants for the multi-channel NCO: quadrant encoding,
// pipeline latency and dither LFSR parameters.
package nco_mc_pkg;

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quad_t;

    localparam int          PIPE_LAT  = 4;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Channel index width; a single-channel build still carries one bit.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nco_mc_st_if.sv
// Write bus into the NCO shadow registers (frequency word / phase offset).
interface nco_mc_st_if
    import nco_mc_pkg::*;
#(
    parameter int APR = 32,
    parameter int NCH = 4
);
    logic                  wr_en;
    logic [ch_w(NCH)-1:0]  wr_ch;
    logic                  wr_sel;
    logic [APR-1:0]        wr_data;

    modport master (output wr_en, wr_ch, wr_sel, wr_data);
    modport slave  (input  wr_en, wr_ch, wr_sel, wr_data);
endinterface

// File: rtl/nco_qw_rom.sv
// Quarter-wave sine ROM with two registered read ports (sine and cosine).
// Entry i holds round((2^(MPR-1)-1) * sin(pi/2 * (i+0.5) / 2^RAW)).
module nco_qw_rom #(
    parameter int MPR = 16,
    parameter int RAW = 10
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           en,
    input  logic [RAW-1:0] addr_a,
    input  logic [RAW-1:0] addr_b,
    output logic [MPR-2:0] data_a,
    output logic [MPR-2:0] data_b
);
    localparam int  DEPTH = 1 << RAW;
    localparam real AMP   = (2.0 ** (MPR - 1)) - 1.0;
    localparam real PI    = 3.14159265358979323846;

    logic [MPR-2:0] rom [DEPTH];

    // Half-step offset keeps the table symmetric so no entry hits zero or overflows.
    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam real X = AMP * $sin(PI / 2.0 * (real'(i) + 0.5) / real'(DEPTH));
        assign rom[i] = (MPR-1)'($rtoi(X + 0.5));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_a <= '0;
            data_b <= '0;
        end else if (en) begin
            data_a <= rom[addr_a];
            data_b <= rom[addr_b];
        end
    end

endmodule

// File: rtl/nco_mc_st.sv
// Time-multiplexed multi-channel NCO with shadowed, frame-coherent retuning.
// Define NCO_MC_DITHER_EN to add LFSR dither below the LUT address bits.
module nco_mc_st
    import nco_mc_pkg::*;
#(
    parameter int MPR = 16,
    parameter int APR = 32,
    parameter int RAW = 10,
    parameter int NCH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clken,
    input  logic                  phase_clr,
    nco_mc_st_if.slave            wr,
    output logic signed [MPR-1:0] fsin_o,
    output logic signed [MPR-1:0] fcos_o,
    output logic [ch_w(NCH)-1:0]  out_ch,
    output logic                  out_valid
);
    localparam int CHW = ch_w(NCH);
    localparam int LOW = APR - 2 - RAW;

    logic [APR-1:0] acc     [NCH];
    logic [APR-1:0] freq    [NCH];
    logic [APR-1:0] poff    [NCH];
    logic [APR-1:0] freq_sh [NCH];
    logic [APR-1:0] poff_sh [NCH];

    logic [CHW-1:0] slot;
    logic           clr_pend;
    logic           commit;
    logic           clr_now;
    logic [APR-1:0] step, offs, base, phase;

    assign commit  = clken && (slot == '0);
    assign clr_now = commit && clr_pend;

`ifdef NCO_MC_DITHER_EN
    localparam int DSH = (LOW >= 16) ? 0 : 16 - LOW;
    logic [15:0]    lfsr;
    logic [APR-1:0] dith;

    assign dith = APR'(lfsr >> DSH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   lfsr <= LFSR_SEED;
        else if (clken) lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end
`endif

    // A commit cycle already runs channel 0 with the freshly committed values.
    always_comb begin
        step  = commit  ? freq_sh[slot] : freq[slot];
        offs  = commit  ? poff_sh[slot] : poff[slot];
        base  = clr_now ? '0 : acc[slot];
        phase = base + offs;
`ifdef NCO_MC_DITHER_EN
        phase = phase + dith;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                freq_sh[i] <= '0;
                poff_sh[i] <= '0;
            end
        end else if (wr.wr_en && (int'(wr.wr_ch) < NCH)) begin
            if (wr.wr_sel) poff_sh[wr.wr_ch] <= wr.wr_data;
            else           freq_sh[wr.wr_ch] <= wr.wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                acc[i]  <= '0;
                freq[i] <= '0;
                poff[i] <= '0;
            end
            slot     <= '0;
            clr_pend <= 1'b0;
        end else begin
            if (phase_clr)    clr_pend <= 1'b1;
            else if (clr_now) clr_pend <= 1'b0;
            if (clken) begin
                slot <= (int'(slot) == NCH - 1) ? '0 : slot + CHW'(1);
                if (commit) begin
                    for (int i = 0; i < NCH; i++) begin
                        freq[i] <= freq_sh[i];
                        poff[i] <= poff_sh[i];
                        if (clr_now) acc[i] <= '0;
                    end
                end
                acc[slot] <= base + step;
            end
        end
    end

    quad_t                 q1, q2;
    logic [RAW-1:0]        a1, sin_addr, cos_addr;
    logic [CHW-1:0]        ch1, ch2, ch3;
    logic [MPR-2:0]        sin_lut, cos_lut;
    logic signed [MPR-1:0] sin_mag, cos_mag, sin_val, cos_val, sn3, cs3;
    logic [PIPE_LAT-1:0]   vld_sr;
    logic                  unused_low;

    assign unused_low = ^phase[LOW-1:0];

    // Sine mirrors in odd quadrants; cosine is the same wave a quadrant ahead.
    assign sin_addr = (q1 == QUAD_1 || q1 == QUAD_3) ? ~a1 : a1;
    assign cos_addr = (q1 == QUAD_1 || q1 == QUAD_3) ? a1 : ~a1;

    nco_qw_rom #(.MPR(MPR), .RAW(RAW)) u_rom (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (clken),
        .addr_a  (sin_addr),
        .addr_b  (cos_addr),
        .data_a  (sin_lut),
        .data_b  (cos_lut)
    );

    always_comb begin
        sin_mag = signed'({1'b0, sin_lut});
        cos_mag = signed'({1'b0, cos_lut});
        sin_val = (q2 == QUAD_2 || q2 == QUAD_3) ? -sin_mag : sin_mag;
        cos_val = (q2 == QUAD_1 || q2 == QUAD_2) ? -cos_mag : cos_mag;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q1     <= QUAD_0;
            a1     <= '0;
            ch1    <= '0;
            q2     <= QUAD_0;
            ch2    <= '0;
            sn3    <= '0;
            cs3    <= '0;
            ch3    <= '0;
            fsin_o <= '0;
            fcos_o <= '0;
            out_ch <= '0;
            vld_sr <= '0;
        end else if (clken) begin
            q1     <= quad_t'(phase[APR-1 -: 2]);
            a1     <= phase[APR-3 -: RAW];
            ch1    <= slot;
            q2     <= q1;
            ch2    <= ch1;
            sn3    <= sin_val;
            cs3    <= cos_val;
            ch3    <= ch2;
            fsin_o <= sn3;
            fcos_o <= cs3;
            out_ch <= ch3;
            vld_sr <= {vld_sr[PIPE_LAT-2:0], 1'b1};
        end
    end

    assign out_valid = clken & vld_sr[PIPE_LAT-1];

endmodule

// File: tb/tb_nco_mc_st.sv
// Directed bench for nco_mc_st: a 4-channel and a 1-channel instance sharing clock/clken.
module tb_nco_mc_st;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, clken, phase_clr;

    nco_mc_st_if #(.APR(32), .NCH(4)) wr4 ();
    nco_mc_st_if #(.APR(32), .NCH(1)) wr1 ();

    logic signed [15:0] fsin4, fcos4, fsin1, fcos1;
    logic [1:0]         out_ch4;
    logic [0:0]         out_ch1;
    logic               out_valid4, out_valid1;

    nco_mc_st #(.MPR(16), .APR(32), .RAW(10), .NCH(4)) u_dut4 (
        .clk       (clk),
        .reset_n   (reset_n),
        .clken     (clken),
        .phase_clr (phase_clr),
        .wr        (wr4),
        .fsin_o    (fsin4),
        .fcos_o    (fcos4),
        .out_ch    (out_ch4),
        .out_valid (out_valid4)
    );

    nco_mc_st #(.MPR(16), .APR(32), .RAW(10), .NCH(1)) u_dut1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .clken     (clken),
        .phase_clr (phase_clr),
        .wr        (wr1),
        .fsin_o    (fsin1),
        .fcos_o    (fcos1),
        .out_ch    (out_ch1),
        .out_valid (out_valid1)
    );

    int tests = 0;
    int fails = 0;

    logic [31:0] m_acc [4];
    logic [31:0] m_fr  [4];
    logic [31:0] m_po  [4];
    logic [31:0] m_fsh [4];
    logic [31:0] m_psh [4];
    int          m_slot;
    bit          m_pend;
    int          q_ch [$];
    int          q_s  [$];
    int          q_c  [$];
    int          last_s, last_c, last_ch;
    bit          chk1;
    int          k1;
    int          s1_tab [4];
    int          c1_tab [4];

    function automatic int lut_ref(input int i);
        real x = 32767.0 * $sin(3.14159265358979 * (real'(i) + 0.5) / 2048.0);
        return $rtoi(x + 0.5);
    endfunction

    function automatic int ref_sin(input logic [31:0] ph);
        int a = int'(ph[29:20]);
        int q = int'(ph[31:30]);
        int m = lut_ref((q % 2 == 1) ? 1023 - a : a);
        return (q >= 2) ? -m : m;
    endfunction

    function automatic int ref_cos(input logic [31:0] ph);
        return ref_sin(ph + 32'h4000_0000);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < 4; j++) begin
            m_acc[j] = '0; m_fr[j] = '0; m_po[j] = '0; m_fsh[j] = '0; m_psh[j] = '0;
        end
        m_slot = 0; m_pend = 1'b0;
        q_ch.delete(); q_s.delete(); q_c.delete();
        last_s = 0; last_c = 0; last_ch = 0;
    endtask

    task automatic model_step();
        logic [31:0] ph;
        if (m_slot == 0) begin
            for (int j = 0; j < 4; j++) begin
                m_fr[j] = m_fsh[j];
                m_po[j] = m_psh[j];
                if (m_pend) m_acc[j] = '0;
            end
            m_pend = 1'b0;
        end
        ph = m_acc[m_slot] + m_po[m_slot];
        m_acc[m_slot] = m_acc[m_slot] + m_fr[m_slot];
        q_ch.push_back(m_slot);
        q_s.push_back(ref_sin(ph));
        q_c.push_back(ref_cos(ph));
        m_slot = (m_slot + 1) % 4;
    endtask

    task automatic set_wr4(input int ch, input bit sel, input logic [31:0] d);
        wr4.wr_en = 1'b1; wr4.wr_ch = 2'(ch); wr4.wr_sel = sel; wr4.wr_data = d;
    endtask

    // One clock: model consumes this cycle's inputs, then outputs are checked #1 after the edge.
    task automatic cycle();
        bit en;
        int ech, es, ec;
        en = clken;
        if (en) model_step();
        if (wr4.wr_en) begin
            if (wr4.wr_sel) m_psh[wr4.wr_ch] = wr4.wr_data;
            else            m_fsh[wr4.wr_ch] = wr4.wr_data;
        end
        if (phase_clr) m_pend = 1'b1;
        @(posedge clk); #1;
        wr4.wr_en = 1'b0; wr1.wr_en = 1'b0; phase_clr = 1'b0;
        if (!en) begin
            chk("stall_valid", out_valid4, 0);
            chk("stall_sin", fsin4, last_s);
            chk("stall_cos", fcos4, last_c);
            chk("stall_ch", out_ch4, last_ch);
        end else if (q_ch.size() == 4) begin
            ech = q_ch.pop_front(); es = q_s.pop_front(); ec = q_c.pop_front();
            chk("valid4", out_valid4, 1);
            chk("ch4", out_ch4, ech);
            chk("sin4", fsin4, es);
            chk("cos4", fcos4, ec);
            last_s = es; last_c = ec; last_ch = ech;
            if (chk1 && k1 < 8) begin
                chk("valid1", out_valid1, 1);
                chk("sin1", fsin1, s1_tab[k1 % 4]);
                chk("cos1", fcos1, c1_tab[k1 % 4]);
                k1++;
            end
        end else begin
            chk("fill_valid4", out_valid4, 0);
        end
    endtask

    initial begin
        s1_tab = '{25, 32767, -25, -32767};
        c1_tab = '{32767, -25, -32767, 25};
        reset_n = 1'b0; clken = 1'b0; phase_clr = 1'b0;
        wr4.wr_en = 1'b0; wr4.wr_ch = '0; wr4.wr_sel = 1'b0; wr4.wr_data = '0;
        wr1.wr_en = 1'b0; wr1.wr_ch = '0; wr1.wr_sel = 1'b0; wr1.wr_data = '0;
        chk1 = 1'b0; k1 = 0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_sin4", fsin4, 0);
        chk("rst_cos4", fcos4, 0);
        chk("rst_ch4", out_ch4, 0);
        chk("rst_valid4", out_valid4, 0);
        chk("rst_sin1", fsin1, 0);
        chk("rst_valid1", out_valid1, 0);
        reset_n = 1'b1;

        // Program while stalled; the second ch0 freq write must win.
        set_wr4(0, 1'b0, 32'h1111_1111); cycle();
        set_wr4(0, 1'b0, 32'h1234_5678);
        wr1.wr_en = 1'b1; wr1.wr_ch = 1'b0; wr1.wr_sel = 1'b0; wr1.wr_data = 32'h4000_0000;
        cycle();
        set_wr4(0, 1'b1, 32'h4000_0000); cycle();
        set_wr4(1, 1'b0, 32'h1234_5678); cycle();
        set_wr4(2, 1'b0, 32'h0800_0000); cycle();
        set_wr4(3, 1'b0, 32'h2468_ACE0); cycle();

        clken = 1'b1; chk1 = 1'b1;
        repeat (25) cycle();
        chk1 = 1'b0;

        // Mid-frame retune of channel 2 (current slot 1).
        set_wr4(2, 1'b0, 32'h0100_0000); cycle();
        repeat (10) cycle();

        // Write coinciding with a commit (slot 0): old value commits first.
        set_wr4(3, 1'b0, 32'h0300_0000); cycle();
        repeat (7) cycle();
        repeat (6) cycle();

        // Clear request, then a 3-cycle stall.
        phase_clr = 1'b1; cycle();
        clken = 1'b0;
        repeat (3) cycle();
        clken = 1'b1;
        repeat (16) cycle();

        // Uncommitted write followed by a mid-stream reset.
        repeat (2) cycle();
        set_wr4(0, 1'b0, 32'h5555_5555); cycle();
        reset_n = 1'b0;
        #1;
        chk("mrst_sin4", fsin4, 0);
        chk("mrst_cos4", fcos4, 0);
        chk("mrst_ch4", out_ch4, 0);
        chk("mrst_valid4", out_valid4, 0);
        chk("mrst_sin1", fsin1, 0);
        chk("mrst_valid1", out_valid1, 0);
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (10) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
